// File: rtl/intr_dispatch.sv
// Interrupt dispatcher: masks the pending vector, arbitrates one winner and runs the
// irq/ack/eoi handshake, then strobes a one-hot clear back to the pending-latch block.
// Optional macro INTR_DISPATCH_RR_EN selects round-robin arbitration (default: lowest index wins).
//
// state   | meaning
// IDLE    | waiting for an eligible line
// REQ     | irq raised, waiting for ack (may retract)
// SERVICE | handler running, waiting for eoi
// CLEAR   | one-cycle clear strobe to the pending-latch block
module intr_dispatch #(
  parameter int INTR_NUM = 8,
  parameter int ID_W     = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [INTR_NUM-1:0] i_intr_sig,
  input  logic [INTR_NUM-1:0] i_intr_mask,
  input  logic                i_irq_ack,
  input  logic                i_irq_eoi,
  output logic                o_irq,
  output logic [ID_W-1:0]     o_irq_id,
  output logic                o_irq_busy,
  output logic                o_intr_clr,
  output logic [INTR_NUM-1:0] o_intr_clr_sel
);

  localparam int IDX_W = (INTR_NUM > 1) ? $clog2(INTR_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2,
    S_CLEAR   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_irq;
  logic [ID_W-1:0]     r_irq_id;
  logic                r_irq_busy;
  logic                r_intr_clr;
  logic [INTR_NUM-1:0] r_intr_clr_sel;

  logic [INTR_NUM-1:0] w_eligible;
  logic                w_win_vld;
  logic [IDX_W-1:0]    w_win_idx;
  logic [IDX_W-1:0]    w_cur_idx;
  logic                w_irq_nxt;
  logic [ID_W-1:0]     w_id_nxt;
  logic                w_busy_nxt;
  logic                w_clr_nxt;
  logic [INTR_NUM-1:0] w_sel_nxt;

  function automatic logic [IDX_W-1:0] f_lowest(input logic [INTR_NUM-1:0] v);
    f_lowest = '0;
    for (int i = INTR_NUM - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = IDX_W'(i);
    end
  endfunction

  assign w_eligible = i_intr_sig & i_intr_mask;
  assign w_win_vld  = |w_eligible;
  assign w_cur_idx  = r_irq_id[IDX_W-1:0];

`ifdef INTR_DISPATCH_RR_EN
  // Search starts just above the last serviced line; reset value makes the first grant match fixed priority.
  logic [IDX_W-1:0]    r_last_served;
  logic [INTR_NUM-1:0] w_above;
  logic [INTR_NUM-1:0] w_elig_hi;

  always_comb begin
    w_above = '0;
    for (int i = 0; i < INTR_NUM; i++) begin
      w_above[i] = (i > int'(r_last_served));
    end
  end

  assign w_elig_hi = w_eligible & w_above;
  assign w_win_idx = (|w_elig_hi) ? f_lowest(w_elig_hi) : f_lowest(w_eligible);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_served <= IDX_W'(INTR_NUM - 1);
    end else if (r_state == S_SERVICE && i_irq_eoi) begin
      r_last_served <= w_cur_idx;
    end
  end
`else
  assign w_win_idx = f_lowest(w_eligible);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_irq_id;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_REQ;
          w_id_nxt    = ID_W'(w_win_idx);
        end
      end
      S_REQ: begin
        // ack beats retraction when both happen in the same cycle
        if (i_irq_ack)                     w_state_nxt = S_SERVICE;
        else if (!w_eligible[w_cur_idx])   w_state_nxt = S_IDLE;
      end
      S_SERVICE: begin
        if (i_irq_eoi) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_irq_nxt  = (w_state_nxt == S_REQ);
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_clr_nxt  = (w_state_nxt == S_CLEAR);
    w_sel_nxt  = '0;
    if (w_clr_nxt) w_sel_nxt[w_cur_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_irq          <= 1'b0;
      r_irq_id       <= '0;
      r_irq_busy     <= 1'b0;
      r_intr_clr     <= 1'b0;
      r_intr_clr_sel <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_irq          <= w_irq_nxt;
      r_irq_id       <= w_id_nxt;
      r_irq_busy     <= w_busy_nxt;
      r_intr_clr     <= w_clr_nxt;
      r_intr_clr_sel <= w_sel_nxt;
    end
  end

  assign o_irq          = r_irq;
  assign o_irq_id       = r_irq_id;
  assign o_irq_busy     = r_irq_busy;
  assign o_intr_clr     = r_intr_clr;
  assign o_intr_clr_sel = r_intr_clr_sel;

endmodule

// File: tb/tb_intr_dispatch.sv
// Directed bench for intr_dispatch: expected grants and clear selects are queued when
// stimulus is applied and compared when the dispatcher produces them.
module tb_intr_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sig = '0;
  logic [7:0] mask = '0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;
  logic       irq;
  logic [2:0] irq_id;
  logic       busy;
  logic       clr;
  logic [7:0] clr_sel;

  int checks = 0;
  int failures = 0;
  int clr_cnt = 0;
  int exp_id_q[$];
  logic [7:0] exp_sel_q[$];

  intr_dispatch #(.INTR_NUM(8), .ID_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_intr_sig(sig), .i_intr_mask(mask),
    .i_irq_ack(ack), .i_irq_eoi(eoi), .o_irq(irq), .o_irq_id(irq_id),
    .o_irq_busy(busy), .o_intr_clr(clr), .o_intr_clr_sel(clr_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (clr) clr_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for irq, then compares latency and the queued expected id.
  task automatic grant(input string tag);
    int n;
    int e;
    n = 0;
    while (irq !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    e = (exp_id_q.size() > 0) ? exp_id_q.pop_front() : -1;
    chk({tag, "_irq"}, 32'(irq), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'd1);
    chk({tag, "_id"}, 32'(irq_id), 32'(e));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  // Called on the cycle after eoi: clear must be up now, for exactly one cycle.
  task automatic clear(input string tag, input logic [7:0] new_sig);
    logic [7:0] e;
    e = (exp_sel_q.size() > 0) ? exp_sel_q.pop_front() : 8'hxx;
    chk({tag, "_clr"}, 32'(clr), 32'd1);
    chk({tag, "_sel"}, 32'(clr_sel), 32'(e));
    sig = new_sig;
    step();
    chk({tag, "_clr_end"}, 32'(clr), 32'd0);
    chk({tag, "_sel_end"}, 32'(clr_sel), 32'd0);
  endtask

  task automatic do_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic do_eoi(input logic [7:0] sel);
    exp_sel_q.push_back(sel);
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    int c0;
    int arb_exp[4];
`ifdef INTR_DISPATCH_RR_EN
    arb_exp = '{0, 2, 0, 2};
`else
    arb_exp = '{0, 0, 0, 0};
`endif
    step(2);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_clr", 32'(clr), 0);
    chk("rst_sel", 32'(clr_sel), 0);
    chk("rst_id", 32'(irq_id), 0);
    rst = 1'b0;
    step();

    // basic handshake
    sig = 8'h24; mask = 8'hFF; exp_id_q.push_back(2);
    grant("basic_g2");
    do_ack();
    chk("basic_ack_irq", 32'(irq), 0);
    chk("basic_ack_busy", 32'(busy), 1);
    do_eoi(8'h04);
    clear("basic_c2", 8'h20);
    exp_id_q.push_back(5);
    grant("basic_g5");
    do_ack(); do_eoi(8'h20);
    clear("basic_c5", 8'h00);

    // masking
    sig = 8'h01; mask = 8'hFE;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mask_hold_irq", 32'(irq), 0);
    end
    mask = 8'hFF; exp_id_q.push_back(0);
    grant("mask_g0");
    do_ack(); do_eoi(8'h01);
    clear("mask_c0", 8'h00);

    // retraction, then ack beating retraction
    sig = 8'h08; exp_id_q.push_back(3);
    grant("retr_g3");
    c0 = clr_cnt;
    mask = 8'hF7;
    step();
    chk("retr_irq", 32'(irq), 0);
    chk("retr_busy", 32'(busy), 0);
    step(3);
    chk("retr_idle_busy", 32'(busy), 0);
    chk("retr_no_clr", 32'(clr_cnt), 32'(c0));
    mask = 8'hFF; exp_id_q.push_back(3);
    grant("retr_g3b");
    mask = 8'hF7; ack = 1'b1;
    step();
    ack = 1'b0; mask = 8'hFF;
    chk("ackwin_irq", 32'(irq), 0);
    chk("ackwin_busy", 32'(busy), 1);
    step();
    chk("ackwin_stay_irq", 32'(irq), 0);
    chk("ackwin_stay_busy", 32'(busy), 1);

    // spurious handshakes
    do_ack();
    chk("sp_ack_busy", 32'(busy), 1);
    chk("sp_ack_irq", 32'(irq), 0);
    chk("sp_ack_clr", 32'(clr), 0);
    do_eoi(8'h08);
    clear("sp_c3", 8'h00);
    c0 = clr_cnt;
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("sp_eoi_idle_busy", 32'(busy), 0);
    chk("sp_eoi_idle_clr", 32'(clr), 0);
    sig = 8'h10; exp_id_q.push_back(4);
    grant("sp_g4");
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("sp_eoi_req_irq", 32'(irq), 1);
    chk("sp_eoi_req_id", 32'(irq_id), 4);
    step();
    chk("sp_no_clr", 32'(clr_cnt), 32'(c0));
    do_ack();
    chk("svc_busy", 32'(busy), 1);

    // async reset mid-SERVICE
    rst = 1'b1;
    #1;
    chk("arst_irq", 32'(irq), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_clr", 32'(clr), 0);
    chk("arst_sel", 32'(clr_sel), 0);
    sig = 8'h00;
    step();
    rst = 1'b0;
    step(3);
    chk("arst_idle_busy", 32'(busy), 0);
    chk("arst_idle_irq", 32'(irq), 0);
    chk("arst_no_clr", 32'(clr_cnt), 32'(c0));

    // arbitration with lines 0 and 2 permanently pending
    sig = 8'h05;
    for (int k = 0; k < 4; k++) begin
      exp_id_q.push_back(arb_exp[k]);
      grant("arb_g");
      do_ack();
      do_eoi(8'(1 << arb_exp[k]));
      clear("arb_c", 8'h05);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
